width_split: RTL and testbench
==============================

// Module: width_split
// PURPOSE
//  Avalon-MM width adapter, 32-bit slave side to 8-bit master side. Splits each 32-bit
//  access into sequential byte accesses on lanes 0..3, out_address = {in_address, lane}.
//  Bridges the 32-bit CPU/system interconnect to 8-bit peripherals (byte-wide register files).
// PARAMETERS
//  IN_ADDR_W   7   in_address width (word address); out_address width is IN_ADDR_W+2
// PORTS
//  clk              in   1            clock
//  reset            in   1            asynchronous, active-high reset
//  in_address       in   IN_ADDR_W    32-bit word address
//  in_read          in   1            read request, held while in_waitrequest=1
//  in_write         in   1            write request, held while in_waitrequest=1
//  in_writedata     in   32           write data
//  in_byteenable    in   4            byte lane enables, bit n = bits [8n+7:8n]
//  in_readdata      out  32           assembled read data, valid when in_read && !in_waitrequest
//  in_waitrequest   out  1            stall to 32-bit master
//  out_address      out  IN_ADDR_W+2  byte address {addr_q, lane_q}
//  out_read         out  1            byte read strobe
//  out_write        out  1            byte write strobe
//  out_writedata    out  8            byte write data = wdata_q[8*lane_q+7 -: 8]
//  out_readdata     in   8            byte read data, valid when out_read && !out_waitrequest
//  out_waitrequest  in   1            stall from 8-bit slave
// BEHAVIOUR
//  - FSM states: IDLE, XFER, DONE. Reset: state=IDLE, lane_q=0, rdata_q=0, all latches 0.
//  - Outputs decoded from registers: in_waitrequest = (state!=DONE); out_read = (state==XFER)
//    && is_rd_q; out_write = (state==XFER) && !is_rd_q; in_readdata = rdata_q.
//    Reset values: in_waitrequest=1, out_read=0, out_write=0, out_address=0, in_readdata=0.
//  - IDLE: on in_read|in_write latch address, writedata, byteenable, is_rd_q=in_read (read wins
//    if both); set lane_q = first lane to access; clear rdata_q. If no lane to access -> DONE,
//    else -> XFER.
//  - XFER: hold out_* stable while out_waitrequest=1. On accept (!out_waitrequest): for reads
//    store out_readdata into rdata_q[8*lane_q+7 -: 8]; advance lane_q to next lane to access;
//    after last lane -> DONE.
//  - DONE: in_waitrequest=0 for exactly one cycle, then IDLE. Master drops its request on that
//    edge; a new request is sampled in IDLE on the following cycle (no back-to-back accept).
//  - Latency, zero-wait 8-bit slave, 4 lanes: request at cycle 0, lanes at cycles 1-4,
//    in_waitrequest low at cycle 5. Each out_waitrequest cycle adds one.
//  - Writes always skip lanes with byteenable=0 (never corrupt unselected bytes).
//    byteenable=0 write -> IDLE->DONE, no out_write.
//  - Lanes accessed in ascending order only; lane_q never wraps past 3.
//  - in_read/in_write changes outside IDLE are ignored (latched values used).
//  - Reset asserted mid-transfer: immediately IDLE, out_read/out_write drop asynchronously,
//    partial rdata_q discarded. The 8-bit slave sees an aborted access.
// CONFIGURATION
//  SKIP_DISABLED_LANES_EN defined: reads also skip lanes with byteenable=0; skipped bytes of
//    in_readdata read 8'h00; byteenable=0 read -> DONE with no out_read
//    (in_waitrequest low at cycle 1).
//  Not defined: reads always access all four lanes regardless of byteenable
//    (peripherals with read side effects see every byte). Write behaviour is identical.
// TESTING
//  1 Read, be=4'hF, slave bytes 11,22,33,44 zero-wait -> out_address a*4+0..3 cycles 1-4,
//    in_readdata=32'h44332211, in_waitrequest low at cycle 5 only.
//  2 Write 32'hA1B2C3D4 be=4'b0101 -> exactly two out_write: lane0 8'hD4, lane2 8'hB2;
//    in_waitrequest low at cycle 3.
//  3 Read be=4'hF, out_waitrequest high 2 cycles on lane 1 -> out_address/out_read held stable;
//    completion delayed to cycle 7, data intact.
//  4 Read be=4'b0010: macro on -> one out_read lane1, in_readdata=32'h0000XX00;
//    macro off -> 4 out_reads, all bytes returned.
//  5 Write be=0 -> no out_write, in_waitrequest low cycle 1; read be=0 with macro on, same.
//  6 Reset pulse during lane 2 of a read -> out_read 0 same cycle, in_waitrequest=1,
//    in_readdata=0; next read completes normally.

Source files
------------

// File: rtl/width_split.sv
// width_split: Avalon-MM 32-bit slave to 8-bit master width adapter, one byte lane per access.
// Optional macro SKIP_DISABLED_LANES_EN: reads also skip lanes whose byteenable bit is 0.
`default_nettype none

module width_split #(
    parameter int IN_ADDR_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_ADDR_W-1:0] in_address,
    input  logic                 in_read,
    input  logic                 in_write,
    input  logic [31:0]          in_writedata,
    input  logic [3:0]           in_byteenable,
    output logic [31:0]          in_readdata,
    output logic                 in_waitrequest,
    output logic [IN_ADDR_W+1:0] out_address,
    output logic                 out_read,
    output logic                 out_write,
    output logic [7:0]           out_writedata,
    input  logic [7:0]           out_readdata,
    input  logic                 out_waitrequest
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [IN_ADDR_W-1:0]   addr_q, addr_n;
    logic [31:0]            wdata_q, wdata_n;
    logic [31:0]            rdata_q, rdata_n;
    logic [3:0]             mask_q, mask_n;
    logic                   is_rd_q, is_rd_n;
    logic [1:0]             lane_q, lane_n;
    logic [3:0]             req_mask;
    logic [2:0]             first_lane;
    logic [2:0]             next_lane;

    // Lowest set lane at or above 'from'; 3'd4 means no lane left.
    function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] from);
        find_lane = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                find_lane = 3'(i);
            end
        end
    endfunction

`ifdef SKIP_DISABLED_LANES_EN
    assign req_mask = in_byteenable;
`else
    assign req_mask = in_read ? 4'hF : in_byteenable;
`endif

    assign first_lane = find_lane(req_mask, 3'd0);
    assign next_lane  = find_lane(mask_q, {1'b0, lane_q} + 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
            is_rd_q <= 1'b0;
            lane_q  <= 2'd0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            mask_q  <= mask_n;
            is_rd_q <= is_rd_n;
            lane_q  <= lane_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        mask_n  = mask_q;
        is_rd_n = is_rd_q;
        lane_n  = lane_q;
        case (state)
            IDLE: begin
                if (in_read || in_write) begin
                    addr_n  = in_address;
                    wdata_n = in_writedata;
                    mask_n  = req_mask;
                    is_rd_n = in_read;
                    rdata_n = '0;
                    if (first_lane[2]) begin
                        lane_n  = 2'd0;
                        state_n = DONE;
                    end else begin
                        lane_n  = first_lane[1:0];
                        state_n = XFER;
                    end
                end
            end
            XFER: begin
                if (!out_waitrequest) begin
                    if (is_rd_q) begin
                        rdata_n[8*lane_q +: 8] = out_readdata;
                    end
                    if (next_lane[2]) begin
                        state_n = DONE;
                    end else begin
                        lane_n = next_lane[1:0];
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_waitrequest = (state != DONE);
    assign out_read       = (state == XFER) && is_rd_q;
    assign out_write      = (state == XFER) && !is_rd_q;
    assign in_readdata    = rdata_q;
    assign out_address    = {addr_q, lane_q};
    assign out_writedata  = wdata_q[8*lane_q +: 8];

endmodule

`default_nettype wire

// File: tb/tb_width_split.sv
// Directed, table-driven testbench for width_split.
`default_nettype none

module tb_width_split;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  in_address;
    logic        in_read;
    logic        in_write;
    logic [31:0] in_writedata;
    logic [3:0]  in_byteenable;
    logic [31:0] in_readdata;
    logic        in_waitrequest;
    logic [8:0]  out_address;
    logic        out_read;
    logic        out_write;
    logic [7:0]  out_writedata;
    logic [7:0]  out_readdata;
    logic        out_waitrequest;

    int checks = 0;
    int errors = 0;

    width_split #(.IN_ADDR_W(7)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_address      (in_address),
        .in_read         (in_read),
        .in_write        (in_write),
        .in_writedata    (in_writedata),
        .in_byteenable   (in_byteenable),
        .in_readdata     (in_readdata),
        .in_waitrequest  (in_waitrequest),
        .out_address     (out_address),
        .out_read        (out_read),
        .out_write       (out_write),
        .out_writedata   (out_writedata),
        .out_readdata    (out_readdata),
        .out_waitrequest (out_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] sdata;
        int          stall_lane;
        int          stall_n;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_lanes;
        int          exp_done;
        logic [31:0] exp_wimg;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic [6:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] sdata, input int sl,
                                input int sn, input logic [31:0] er, input logic [3:0] el,
                                input int ed, input logic [31:0] ew);
        vec_t v;
        v.rd = rd; v.addr = addr; v.wdata = wdata; v.be = be; v.sdata = sdata;
        v.stall_lane = sl; v.stall_n = sn; v.exp_rdata = er; v.exp_lanes = el;
        v.exp_done = ed; v.exp_wimg = ew;
        return v;
    endfunction

    // One transaction against a byte-wide slave model; request issued in cycle 0.
    task automatic run_vec(input vec_t v, input string nm);
        int          cyc = 0;
        int          stall_left = v.stall_n;
        int          last_lane = -1;
        int          lane;
        bit          done = 0;
        bit          prev_stalled = 0;
        logic [8:0]  prev_addr = '0;
        logic [3:0]  lanes = '0;
        logic [31:0] wimg = '0;
        logic [31:0] rdata = '0;
        @(negedge clk);
        in_address = v.addr; in_read = v.rd; in_write = !v.rd;
        in_writedata = v.wdata; in_byteenable = v.be; out_waitrequest = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_read || out_write) begin
                lane = int'(out_address[1:0]);
                check({nm, "_addr"}, 32'(out_address[8:2]), 32'(v.addr));
                check({nm, "_kind"}, 32'(out_read), 32'(v.rd));
                if (prev_stalled) check({nm, "_hold"}, 32'(out_address), 32'(prev_addr));
                if (lane == v.stall_lane && stall_left > 0) begin
                    out_waitrequest = 1'b1;
                    stall_left--;
                    prev_stalled = 1;
                    prev_addr = out_address;
                end else begin
                    out_waitrequest = 1'b0;
                    prev_stalled = 0;
                    check({nm, "_order"}, 32'(lane > last_lane), 32'd1);
                    last_lane = lane;
                    lanes[lane] = 1'b1;
                    if (out_write) wimg[lane*8 +: 8] = out_writedata;
                    out_readdata = v.sdata[lane*8 +: 8];
                end
            end else begin
                if (prev_stalled) check({nm, "_hold_strobe"}, 32'd0, 32'd1);
                prev_stalled = 0;
                out_waitrequest = 1'b0;
            end
            if (!in_waitrequest) begin
                done = 1;
                rdata = in_readdata;
                in_read = 1'b0;
                in_write = 1'b0;
            end
        end
        check({nm, "_done_cycle"}, 32'(done ? cyc : -1), 32'(v.exp_done));
        check({nm, "_lanes"}, 32'(lanes), 32'(v.exp_lanes));
        if (v.rd) check({nm, "_rdata"}, rdata, v.exp_rdata);
        else      check({nm, "_wimg"}, wimg, v.exp_wimg);
        out_waitrequest = 1'b0;
        @(negedge clk);
        check({nm, "_wait_back"}, 32'(in_waitrequest), 32'd1);
    endtask

    initial begin
        int  cyc;
        bit  found;
        reset = 1'b1;
        in_address = '0; in_read = 1'b0; in_write = 1'b0; in_writedata = '0;
        in_byteenable = '0; out_readdata = '0; out_waitrequest = 1'b0;

        vecs[0] = mk(1, 7'h15, 32'h0, 4'hF, 32'h44332211, 0, 0, 32'h44332211, 4'hF, 5, 32'h0);
        vecs[1] = mk(0, 7'h03, 32'hA1B2C3D4, 4'b0101, 32'h0, 0, 0, 32'h0, 4'b0101, 3, 32'h00B200D4);
        vecs[2] = mk(1, 7'h2A, 32'h0, 4'hF, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF, 4'hF, 7, 32'h0);
        vecs[4] = mk(0, 7'h11, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 0, 32'h0, 4'h0, 1, 32'h0);
        vecs[6] = mk(0, 7'h7F, 32'h12345678, 4'b1000, 32'h0, 0, 0, 32'h0, 4'b1000, 2, 32'h12000000);
        vecs[7] = mk(0, 7'h40, 32'hCAFEF00D, 4'hF, 32'h0, 3, 1, 32'h0, 4'hF, 6, 32'hCAFEF00D);
`ifdef SKIP_DISABLED_LANES_EN
        vecs[3] = mk(1, 7'h05, 32'h0, 4'b0010, 32'h8877CC55, 0, 0, 32'h0000CC00, 4'b0010, 2, 32'h0);
        vecs[5] = mk(1, 7'h06, 32'h0, 4'h0, 32'h99999999, 0, 0, 32'h0, 4'h0, 1, 32'h0);
        vecs[8] = mk(1, 7'h07, 32'h0, 4'b1001, 32'h01020304, 0, 3, 32'h01000004, 4'b1001, 6, 32'h0);
`else
        vecs[3] = mk(1, 7'h05, 32'h0, 4'b0010, 32'h8877CC55, 0, 0, 32'h8877CC55, 4'hF, 5, 32'h0);
        vecs[5] = mk(1, 7'h06, 32'h0, 4'h0, 32'h99999999, 0, 0, 32'h99999999, 4'hF, 5, 32'h0);
        vecs[8] = mk(1, 7'h07, 32'h0, 4'b1001, 32'h01020304, 0, 3, 32'h01020304, 4'hF, 8, 32'h0);
`endif

        repeat (2) @(negedge clk);
        check("rst_waitrequest", 32'(in_waitrequest), 32'd1);
        check("rst_out_read", 32'(out_read), 32'd0);
        check("rst_out_write", 32'(out_write), 32'd0);
        check("rst_out_address", 32'(out_address), 32'd0);
        check("rst_readdata", in_readdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset pulse while lane 2 of a read is on the bus.
        @(negedge clk);
        in_address = 7'h0A; in_read = 1'b1; in_write = 1'b0; in_byteenable = 4'hF;
        out_readdata = 8'h5A; out_waitrequest = 1'b0;
        cyc = 0; found = 0;
        while (!found && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (out_read && out_address[1:0] == 2'd2) found = 1;
        end
        check("abort_reached_lane2", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_out_read", 32'(out_read), 32'd0);
        check("abort_out_write", 32'(out_write), 32'd0);
        check("abort_waitrequest", 32'(in_waitrequest), 32'd1);
        check("abort_readdata", in_readdata, 32'd0);
        in_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0], "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
